mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mips_pkg.sv | 39 +++
 rtl/load_align.sv | 26 ++
 rtl/mem_access.sv | 143 ++++++++++++++
 tb/tb_mem_access.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MEM stage: access sizes, access FSM states, lane helpers.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The reserved size code 2'b11 falls into the default arms and behaves as a word.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lo[0];
      default: return (lo == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load formatter: picks the addressed byte/half of a bus word and zero/sign-extends it.
// Latency: combinational. Backpressure: none.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      SZ_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage bus master: one load/store per request on a word bus; MEM_TIMEOUT_EN adds a bus watchdog.
// Latency: 3 cycles minimum (IDLE, BUSY, DONE). Backpressure: mem_stall held until ack (or timeout).
module mem_access
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_memread,
  input  logic        MEM_memwrite,
  input  logic [1:0]  MEM_size,
  input  logic        MEM_unsigned,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_wdata,
  output logic [31:0] MEM_rdata,
  output logic        mem_stall,
  output logic        MEM_misalign,
  output logic        MEM_buserr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_op;
  logic        w_aligned;
  logic        w_start;
  logic        w_ack;
  logic        w_finish;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] w_load_data;

  assign w_op      = MEM_memread | MEM_memwrite;
  assign w_aligned = is_aligned(MEM_size, MEM_addr[1:0]);
  assign w_start   = (r_state == IDLE) & w_op & w_aligned;
  assign w_ack     = (r_state == BUSY) & dmem_ack;

  always_comb begin
    w_state_nxt  = r_state;
    mem_stall    = 1'b0;
    MEM_misalign = 1'b0;
    case (r_state)
      IDLE: begin
        MEM_misalign = w_op & ~w_aligned;
        if (w_start) begin
          mem_stall   = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (w_finish) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Size/sign/lane are captured at issue because inputs may change while BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0000;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      MEM_rdata  <= 32'h0;
      r_lane     <= 2'b00;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
    end else if (w_start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MEM_memwrite;
      dmem_be    <= byte_en(MEM_size, MEM_addr[1:0]);
      dmem_addr  <= {MEM_addr[31:2], 2'b00};
      dmem_wdata <= lane_data(MEM_size, MEM_wdata);
      r_lane     <= MEM_addr[1:0];
      r_size     <= MEM_size;
      r_unsigned <= MEM_unsigned;
    end else if (w_finish) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0000;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      if (w_ack && !dmem_we) MEM_rdata <= w_load_data;
    end
  end

  load_align u_load_align (
    .i_rdata   (dmem_rdata),
    .i_addr    (r_lane),
    .i_size    (r_size),
    .i_unsigned(r_unsigned),
    .o_data    (w_load_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_buserr;
  logic              w_tmo;

  // An ack in the final watchdog cycle still completes normally.
  assign w_tmo = (r_state == BUSY) & ~dmem_ack & (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog   <= '0;
      r_buserr <= 1'b0;
    end else begin
      r_buserr <= w_tmo;
      if ((r_state == BUSY) && !w_finish) r_wdog <= r_wdog + WDOG_W'(1);
      else                                r_wdog <= '0;
    end
  end

  assign MEM_buserr = r_buserr;
  assign w_finish   = w_ack | w_tmo;
`else
  assign MEM_buserr = 1'b0;
  assign w_finish   = w_ack;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: byte-level reference memory, randomized loads/stores, bus responder.
module tb_mem_access;

  localparam int TB_TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_memread, MEM_memwrite, MEM_unsigned;
  logic [1:0]  MEM_size;
  logic [31:0] MEM_addr, MEM_wdata;
  logic [31:0] MEM_rdata;
  logic        mem_stall, MEM_misalign, MEM_buserr;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  mem_access #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite), .MEM_size(MEM_size),
    .MEM_unsigned(MEM_unsigned), .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata),
    .MEM_rdata(MEM_rdata), .mem_stall(mem_stall), .MEM_misalign(MEM_misalign),
    .MEM_buserr(MEM_buserr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mis;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    bit          tmo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  bit          resp_en = 1'b0;
  int          next_delay = 0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic [7:0]  ref_mem[int];
  logic [31:0] bus_mem[int];
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] ref_byte(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic bus_chk(input string tag, input exp_t e);
    chk({tag, "_addr"}, dmem_addr, e.addr);
    chk({tag, "_be"}, {28'h0, dmem_be}, {28'h0, e.be});
    chk({tag, "_we"}, {31'h0, dmem_we}, {31'h0, e.we});
    chk({tag, "_wdata"}, dmem_wdata, e.wdata);
  endtask

  task automatic drive_idle();
    MEM_memread  = 1'b0;
    MEM_memwrite = 1'b0;
    MEM_size     = 2'($urandom_range(0, 3));
    MEM_unsigned = 1'($urandom_range(0, 1));
    MEM_addr     = $urandom;
    MEM_wdata    = $urandom;
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 with the DUT back in IDLE.
  task automatic do_op(input bit rd, input bit wr, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int delay);
    exp_t        e;
    int          nb, be_i;
    bit          saw, done;
    logic [63:0] v;
    if (!rd && !wr) begin
      drive_idle();
      @(posedge clk); #1;
      return;
    end
    nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e.mis   = (addr % nb) != 0;
    e.we    = wr;
    e.addr  = addr & ~32'h3;
    be_i    = ((1 << nb) - 1) << (addr % 4);
    e.be    = be_i[3:0];
    e.wdata = (nb == 1) ? (wdata & 32'hFF) * 32'h01010101 :
              (nb == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
    e.tmo   = delay < 0;
    e.stall = e.tmo ? 1 + TB_TMO : 2 + delay;
    if (!e.mis && !e.tmo) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
      end else begin
        v = 64'h0;
        for (int i = 0; i < nb; i++) v |= 64'(ref_byte(int'(addr) + i)) << (8 * i);
        if (!uns && nb < 4 && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
        last_rdata = v[31:0];
      end
    end
    e.rdata = last_rdata;
    sb_q.push_back(e);
    next_delay   = delay;
    MEM_memread  = rd;
    MEM_memwrite = wr;
    MEM_size     = size;
    MEM_unsigned = uns;
    MEM_addr     = addr;
    MEM_wdata    = wdata;
    if (e.mis) begin
      @(posedge clk); #1;
      drive_idle();
      return;
    end
    saw = 0;
    done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) saw = 1;
      else if (saw) done = 1;
      if (!done && c > 0) begin
        MEM_memread  = 1'($urandom_range(0, 1));
        MEM_memwrite = 1'($urandom_range(0, 1));
        MEM_size     = 2'($urandom_range(0, 3));
        MEM_addr     = $urandom;
        MEM_wdata    = $urandom;
      end
    end
    chk("op_completes_in_budget", {31'h0, done}, 32'h1);
    drive_idle();
    @(posedge clk); #1;
  endtask

  initial begin : responder
    int   k, d, key;
    bit   in_txn;
    logic [31:0] w;
    k = 0; d = 0; in_txn = 0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      if (!resp_en) begin
        in_txn     = 0;
        dmem_ack   = man_ack;
        dmem_rdata = man_rdata;
      end else if (dmem_req) begin
        if (!in_txn) begin in_txn = 1; k = 0; d = next_delay; end
        else k++;
        if (k == d) begin
          dmem_ack = 1'b1;
          key = int'(dmem_addr >> 2);
          w = bus_mem.exists(key) ? bus_mem[key] : 32'h0;
          if (dmem_we) begin
            for (int i = 0; i < 4; i++) if (dmem_be[i]) w[8 * i +: 8] = dmem_wdata[8 * i +: 8];
            bus_mem[key] = w;
            dmem_rdata = $urandom;
          end else begin
            dmem_rdata = w;
          end
        end
      end else begin
        in_txn = 0;
        if ($urandom_range(0, 3) == 0) begin
          dmem_ack   = 1'b1;
          dmem_rdata = $urandom;
        end
      end
    end
  end

  initial begin : monitor
    exp_t cur, item;
    bit   prev_req;
    int   stall_cnt;
    cur = '{default: '0};
    prev_req = 0;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_req = 0;
        stall_cnt = 0;
      end else begin
        if (mem_stall) stall_cnt++;
        if (MEM_misalign) begin
          chk("sb_has_misalign_entry", {31'h0, sb_q.size() != 0}, 32'h1);
          if (sb_q.size() != 0) begin
            item = sb_q.pop_front();
            chk("misalign_expected", {31'h0, item.mis}, 32'h1);
          end
          chk("misalign_no_stall", {31'h0, mem_stall}, 32'h0);
          chk("misalign_no_req", {31'h0, dmem_req}, 32'h0);
        end
        if (dmem_req && !prev_req) begin
          chk("sb_has_req_entry", {31'h0, sb_q.size() != 0}, 32'h1);
          if (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            chk("req_expected", {31'h0, cur.mis}, 32'h0);
          end
          bus_chk("issue", cur);
        end else if (dmem_req) begin
          bus_chk("hold", cur);
          chk("busy_stall", {31'h0, mem_stall}, 32'h1);
        end else begin
          if (prev_req) begin
            chk("done_rdata", MEM_rdata, cur.rdata);
            chk("done_buserr", {31'h0, MEM_buserr}, {31'h0, cur.tmo});
            chk("done_stall_low", {31'h0, mem_stall}, 32'h0);
            chk("stall_cycles", 32'(stall_cnt), 32'(cur.stall));
            stall_cnt = 0;
          end else begin
            chk("idle_buserr", {31'h0, MEM_buserr}, 32'h0);
          end
          chk("idle_bus_zero", {dmem_we, dmem_be, dmem_addr[26:0]}, 32'h0);
          chk("idle_wdata_zero", dmem_wdata, 32'h0);
        end
        prev_req = dmem_req;
      end
    end
  end

  initial begin : time_limit
    #400000;
    $display("FAIL time_limit: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : stimulus
    int          sel, nb;
    logic [1:0]  sz;
    logic [31:0] a;
    rst_n = 1'b1;
    drive_idle();
    #3 rst_n = 1'b0;
    #2;
    chk("reset_rdata", MEM_rdata, 32'h0);
    chk("reset_bus", {dmem_req, dmem_we, dmem_be, dmem_addr[25:0]}, 32'h0);
    chk("reset_wdata", dmem_wdata, 32'h0);
    chk("reset_flags", {29'h0, mem_stall, MEM_misalign, MEM_buserr}, 32'h0);
    @(negedge clk); man_ack = 1'b1; man_rdata = 32'hCAFE_F00D;
    @(negedge clk); man_ack = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ack_in_reset_ignored", MEM_rdata, 32'h0);
    mon_en = 1'b1;
    resp_en = 1'b1;

    do_op(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 1);
    do_op(1, 0, 2'd2, 0, 32'h100, 32'h0, 0);
    do_op(0, 1, 2'd2, 0, 32'h100, 32'h80000000, 2);
    do_op(1, 0, 2'd0, 0, 32'h103, 32'h0, 0);
    do_op(1, 0, 2'd0, 1, 32'h103, 32'h0, 1);
    do_op(0, 1, 2'd1, 0, 32'h202, 32'h1234ABCD, 0);
    do_op(1, 0, 2'd1, 0, 32'h202, 32'h0, 3);
    do_op(1, 0, 2'd2, 0, 32'h101, 32'h0, 0);
    do_op(1, 1, 2'd0, 0, 32'h105, 32'h000000A5, 1);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      sz  = 2'($urandom_range(0, 3));
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a   = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
      do_op(sel >= 1 && sel <= 5 || sel == 9, sel >= 6, sz, 1'($urandom_range(0, 1)),
            a, $urandom, $urandom_range(0, 3));
    end

    do_op(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0);
    do_op(1, 0, 2'd2, 0, 32'h100, 32'h0, 0);
    repeat (2) @(negedge clk);
    chk("sb_drained_before_reset", 32'(sb_q.size()), 32'h0);

    // Asynchronous reset in the middle of a load.
    @(posedge clk); #1;
    mon_en = 1'b0;
    resp_en = 1'b0;
    MEM_memread = 1'b1; MEM_memwrite = 1'b0; MEM_size = 2'd2; MEM_addr = 32'h100;
    @(posedge clk); #1;
    chk("pre_reset_req", {31'h0, dmem_req}, 32'h1);
    chk("pre_reset_rdata", MEM_rdata, 32'hDEADBEEF);
    #2;
    rst_n = 1'b0;
    MEM_memread = 1'b0;
    #1;
    chk("midreset_req", {31'h0, dmem_req}, 32'h0);
    chk("midreset_rdata", MEM_rdata, 32'h0);
    chk("midreset_stall", {31'h0, mem_stall}, 32'h0);
    chk("midreset_bus", {dmem_we, dmem_be, dmem_addr[26:0]}, 32'h0);
    @(negedge clk); man_ack = 1'b1; man_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("ack_during_reset_rdata", MEM_rdata, 32'h0);
    @(negedge clk); man_ack = 1'b0; rst_n = 1'b1;
    @(negedge clk); man_ack = 1'b1; man_rdata = 32'h8765_4321;
    @(posedge clk); #1;
    chk("late_ack_rdata", MEM_rdata, 32'h0);
    chk("late_ack_req", {31'h0, dmem_req}, 32'h0);
    chk("late_ack_stall", {31'h0, mem_stall}, 32'h0);
    @(negedge clk); man_ack = 1'b0;
    @(posedge clk); #1;
    last_rdata = 32'h0;
    mon_en = 1'b1;
    resp_en = 1'b1;

    do_op(1, 0, 2'd1, 0, 32'h202, 32'h0, 2);
`ifdef MEM_TIMEOUT_EN
    do_op(1, 0, 2'd2, 0, 32'h104, 32'h0, -1);
    do_op(0, 1, 2'd2, 0, 32'h108, 32'h55AA55AA, -1);
    do_op(1, 0, 2'd2, 0, 32'h108, 32'h0, 0);
`endif
    do_op(1, 0, 2'd0, 1, 32'h203, 32'h0, 0);
    repeat (2) @(negedge clk);
    chk("sb_drained_at_end", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
